// File: rtl/pp_ram_arbiter.sv
//============================================================================
// Module   : pp_ram_arbiter
// Brief    : Shares the single pulse-programmer RAM read port between the
//            pulse sequencer (priority) and the host readback path. Runs one
//            single-word read at a time and skips the address reload when the
//            requested word follows the one just read.
// Options  : define PP_RAM_ARB_TIMEOUT_EN to abort reads whose RAM response
//            never arrives (all-ones data, sticky error_o).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pp_ram_arbiter #(
    parameter int unsigned FAIR_LIMIT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    // Sequencer requester
    input  logic        seq_req_i,
    input  logic [31:0] seq_addr_i,
    output logic        seq_ack_o,
    output logic [63:0] seq_data_o,
    output logic        seq_valid_o,
    // Host requester
    input  logic        host_req_i,
    input  logic [31:0] host_addr_i,
    output logic        host_ack_o,
    output logic [63:0] host_data_o,
    output logic        host_valid_o,
    // RAM controller port
    output logic        ram_set_address_o,
    output logic [31:0] ram_address_o,
    output logic        ram_read_o,
    input  logic [63:0] ram_data_i,
    input  logic        ram_valid_i,
    // Status
    output logic        busy_o,
    output logic        owner_o,
    output logic        error_o
);

    localparam int unsigned FW = $clog2(FAIR_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SET  = 2'd1,
        S_READ = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    state_e        state_q;
    logic [FW-1:0] fair_q;
    logic [31:0]   addr_q;
    logic [31:0]   next_addr_q;
    logic          next_valid_q;

    logic          seq_ack_q;
    logic          host_ack_q;
    logic [63:0]   seq_data_q;
    logic [63:0]   host_data_q;
    logic          seq_valid_q;
    logic          host_valid_q;
    logic          ram_set_q;
    logic [31:0]   ram_address_q;
    logic          ram_read_q;
    logic          busy_q;
    logic          owner_q;
    logic          error_q;

`ifdef PP_RAM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt_q;
`else
    // Timeout logic is compiled out; the parameter stays so both builds share one interface.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    logic        w_grant_seq;
    logic        w_grant_host;
    logic        w_skip;
    logic [31:0] w_grant_addr;

    // Arbitration decision for the current IDLE cycle and address-reload skip test
    always_comb begin
        w_grant_seq  = 1'b0;
        w_grant_host = 1'b0;
        if (state_q == S_IDLE) begin
            if (seq_req_i && host_req_i) begin
                if (fair_q == FW'(FAIR_LIMIT)) begin
                    w_grant_host = 1'b1;
                end else begin
                    w_grant_seq = 1'b1;
                end
            end else if (seq_req_i) begin
                w_grant_seq = 1'b1;
            end else if (host_req_i) begin
                w_grant_host = 1'b1;
            end
        end
        w_grant_addr = w_grant_host ? host_addr_i : seq_addr_i;
        // RAM auto-increments after each read, so a follow-on word needs no reload
        w_skip       = next_valid_q && (w_grant_addr == next_addr_q);
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            fair_q        <= '0;
            addr_q        <= '0;
            next_addr_q   <= '0;
            next_valid_q  <= 1'b0;
            seq_ack_q     <= 1'b0;
            host_ack_q    <= 1'b0;
            seq_data_q    <= '0;
            host_data_q   <= '0;
            seq_valid_q   <= 1'b0;
            host_valid_q  <= 1'b0;
            ram_set_q     <= 1'b0;
            ram_address_q <= '0;
            ram_read_q    <= 1'b0;
            busy_q        <= 1'b0;
            owner_q       <= 1'b0;
            error_q       <= 1'b0;
`ifdef PP_RAM_ARB_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below
            seq_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            seq_valid_q  <= 1'b0;
            host_valid_q <= 1'b0;
            ram_set_q    <= 1'b0;
            ram_read_q   <= 1'b0;

            // Fairness: count sequencer wins only while the host is kept waiting
            if (!host_req_i || w_grant_host) begin
                fair_q <= '0;
            end else if (w_grant_seq && (fair_q != FW'(FAIR_LIMIT))) begin
                fair_q <= fair_q + FW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (w_grant_seq || w_grant_host) begin
                        owner_q    <= w_grant_host;
                        seq_ack_q  <= w_grant_seq;
                        host_ack_q <= w_grant_host;
                        addr_q     <= w_grant_addr;
                        busy_q     <= 1'b1;
                        if (w_skip) begin
                            state_q    <= S_READ;
                            ram_read_q <= 1'b1;
                        end else begin
                            state_q       <= S_SET;
                            ram_set_q     <= 1'b1;
                            ram_address_q <= w_grant_addr;
                        end
                    end
                end

                S_SET: begin
                    state_q    <= S_READ;
                    ram_read_q <= 1'b1;
                end

                S_READ: begin
                    state_q  <= S_WAIT;
`ifdef PP_RAM_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                end

                S_WAIT: begin
                    if (ram_valid_i) begin
                        if (owner_q) begin
                            host_data_q  <= ram_data_i;
                            host_valid_q <= 1'b1;
                        end else begin
                            seq_data_q  <= ram_data_i;
                            seq_valid_q <= 1'b1;
                        end
                        next_addr_q  <= addr_q + 32'd1;
                        next_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
`ifdef PP_RAM_ARB_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // RAM never answered: hand back a poison word and forget the read position
                        if (owner_q) begin
                            host_data_q  <= '1;
                            host_valid_q <= 1'b1;
                        end else begin
                            seq_data_q  <= '1;
                            seq_valid_q <= 1'b1;
                        end
                        error_q      <= 1'b1;
                        next_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seq_ack_o         = seq_ack_q;
    assign seq_data_o        = seq_data_q;
    assign seq_valid_o       = seq_valid_q;
    assign host_ack_o        = host_ack_q;
    assign host_data_o       = host_data_q;
    assign host_valid_o      = host_valid_q;
    assign ram_set_address_o = ram_set_q;
    assign ram_address_o     = ram_address_q;
    assign ram_read_o        = ram_read_q;
    assign busy_o            = busy_q;
    assign owner_o           = owner_q;
    assign error_o           = error_q;

endmodule

`default_nettype wire

// File: tb/tb_pp_ram_arbiter.sv
//============================================================================
// Module   : tb_pp_ram_arbiter
// Brief    : Directed bench for pp_ram_arbiter with a small auto-incrementing
//            RAM responder model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pp_ram_arbiter;

    logic        clk_i;
    logic        reset_n_i;
    logic        seq_req_i;
    logic [31:0] seq_addr_i;
    logic        seq_ack_o;
    logic [63:0] seq_data_o;
    logic        seq_valid_o;
    logic        host_req_i;
    logic [31:0] host_addr_i;
    logic        host_ack_o;
    logic [63:0] host_data_o;
    logic        host_valid_o;
    logic        ram_set_address_o;
    logic [31:0] ram_address_o;
    logic        ram_read_o;
    logic [63:0] ram_data_i;
    logic        ram_valid_i;
    logic        busy_o;
    logic        owner_o;
    logic        error_o;

    int n_vec  = 0;
    int n_miss = 0;

    pp_ram_arbiter #(
        .FAIR_LIMIT     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .seq_req_i         (seq_req_i),
        .seq_addr_i        (seq_addr_i),
        .seq_ack_o         (seq_ack_o),
        .seq_data_o        (seq_data_o),
        .seq_valid_o       (seq_valid_o),
        .host_req_i        (host_req_i),
        .host_addr_i       (host_addr_i),
        .host_ack_o        (host_ack_o),
        .host_data_o       (host_data_o),
        .host_valid_o      (host_valid_o),
        .ram_set_address_o (ram_set_address_o),
        .ram_address_o     (ram_address_o),
        .ram_read_o        (ram_read_o),
        .ram_data_i        (ram_data_i),
        .ram_valid_i       (ram_valid_i),
        .busy_o            (busy_o),
        .owner_o           (owner_o),
        .error_o           (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // RAM content: one special word, otherwise {~addr, addr}
    function automatic logic [63:0] ram_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 64'h0123_4567_89AB_CDEF;
        return {~a, a};
    endfunction

    // RAM responder: auto-increments after each read, answers ram_lat cycles after ram_read_o
    int          ram_lat = 2;
    bit          ram_en  = 1'b1;
    bit          pend    = 1'b0;
    int          pend_cnt;
    logic [31:0] cur_addr = '0;
    logic [31:0] rd_addr;
    always @(negedge clk_i) begin
        ram_valid_i = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                ram_valid_i = 1'b1;
                ram_data_i  = ram_word(rd_addr);
                pend        = 1'b0;
            end else begin
                pend_cnt = pend_cnt - 1;
            end
        end
        if (ram_set_address_o) cur_addr = ram_address_o;
        if (ram_read_o && ram_en) begin
            pend     = 1'b1;
            pend_cnt = ram_lat - 1;
            rd_addr  = cur_addr;
            cur_addr = cur_addr + 32'd1;
        end
    end

    // Event recorder (no checking here)
    int          n_seq_ack = 0, n_host_ack = 0, n_set = 0, n_read = 0;
    int          n_seq_val = 0, n_host_val = 0, n_misroute = 0;
    int          t_ack = 0, t_set = 0, t_read = 0, t_seq_val = 0, t_host_val = 0;
    logic [31:0] last_set_addr = '0;
    bit          last_owner = 1'b0;
    string       grants = "";
    always @(negedge clk_i) begin
        if (seq_ack_o)  begin n_seq_ack++;  t_ack = cyc; grants = {grants, "S"}; last_owner = 1'b0; end
        if (host_ack_o) begin n_host_ack++; t_ack = cyc; grants = {grants, "H"}; last_owner = 1'b1; end
        if (ram_set_address_o) begin n_set++; t_set = cyc; last_set_addr = ram_address_o; end
        if (ram_read_o) begin n_read++; t_read = cyc; end
        if (seq_valid_o)  begin n_seq_val++;  t_seq_val  = cyc; if (last_owner != 1'b0) n_misroute++; end
        if (host_valid_o) begin n_host_val++; t_host_val = cyc; if (last_owner != 1'b1) n_misroute++; end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    // Raise a request, hold it until the ack is seen, then drop it
    task automatic issue(input bit host, input logic [31:0] a, output int t_req, output bit ok);
        ok = 1'b0;
        t_req = cyc;
        if (host) begin host_req_i = 1'b1; host_addr_i = a; end
        else      begin seq_req_i  = 1'b1; seq_addr_i  = a; end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (host ? host_ack_o : seq_ack_o) begin ok = 1'b1; break; end
        end
        if (host) host_req_i = 1'b0; else seq_req_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        seq_req_i = 1'b0; seq_addr_i = '0;
        host_req_i = 1'b0; host_addr_i = '0;
        ram_data_i = '0; ram_valid_i = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({seq_ack_o, seq_valid_o, host_ack_o, host_valid_o, ram_set_address_o, ram_read_o} !== 6'b0) begin
            n_miss++; $display("FAIL reset_strobes: got %b want 000000",
                {seq_ack_o, seq_valid_o, host_ack_o, host_valid_o, ram_set_address_o, ram_read_o});
        end
        n_vec++;
        if ({busy_o, owner_o, error_o} !== 3'b000) begin
            n_miss++; $display("FAIL reset_status: busy/owner/error got %b want 000", {busy_o, owner_o, error_o});
        end
        n_vec++;
        if (seq_data_o !== 64'h0 || host_data_o !== 64'h0 || ram_address_o !== 32'h0) begin
            n_miss++; $display("FAIL reset_data: seq %h host %h addr %h want all zero",
                seq_data_o, host_data_o, ram_address_o);
        end
        reset_n_i = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_seq_read();
        int t_req; bit ok; int sets0;
        sets0 = n_set;
        ram_lat = 2;
        issue(1'b0, 32'h0000_0100, t_req, ok);
        n_vec++;
        if (!ok || t_ack !== t_req + 1) begin
            n_miss++; $display("FAIL seq_ack_latency: ack cycle %0d want %0d (seen %0d)", t_ack, t_req + 1, ok);
        end
        wait_idle(40, ok);
        n_vec++;
        if (!ok) begin n_miss++; $display("FAIL seq_read_done: busy still %b want 0", busy_o); end
        n_vec++;
        if (n_set - sets0 !== 1 || t_set !== t_req + 1 || last_set_addr !== 32'h100) begin
            n_miss++; $display("FAIL seq_set: sets %0d cycle %0d addr %h want 1 %0d 00000100",
                n_set - sets0, t_set, last_set_addr, t_req + 1);
        end
        n_vec++;
        if (t_read !== t_req + 2) begin
            n_miss++; $display("FAIL seq_read_strobe: cycle %0d want %0d", t_read, t_req + 2);
        end
        n_vec++;
        if (n_seq_val !== 1 || t_seq_val !== t_req + 5 || seq_data_o !== 64'h0123_4567_89AB_CDEF) begin
            n_miss++; $display("FAIL seq_valid: count %0d cycle %0d data %h want 1 %0d 0123456789abcdef",
                n_seq_val, t_seq_val, seq_data_o, t_req + 5);
        end
        n_vec++;
        if (n_host_val !== 0 || host_data_o !== 64'h0 || owner_o !== 1'b0) begin
            n_miss++; $display("FAIL seq_host_quiet: host valids %0d data %h owner %b want 0 0 0",
                n_host_val, host_data_o, owner_o);
        end
    endtask

    task automatic test_sequential_skip();
        int t_req; bit ok; int sets0;
        sets0 = n_set;
        issue(1'b0, 32'h0000_0101, t_req, ok);
        wait_idle(40, ok);
        n_vec++;
        if (n_set !== sets0 || t_read !== t_req + 1) begin
            n_miss++; $display("FAIL skip_set: extra sets %0d read cycle %0d want 0 %0d",
                n_set - sets0, t_read, t_req + 1);
        end
        n_vec++;
        if (seq_data_o !== 64'hFFFF_FEFE_0000_0101) begin
            n_miss++; $display("FAIL skip_data: got %h want fffffefe00000101", seq_data_o);
        end
        issue(1'b0, 32'h0000_0200, t_req, ok);
        wait_idle(40, ok);
        n_vec++;
        if (n_set - sets0 !== 1 || last_set_addr !== 32'h200) begin
            n_miss++; $display("FAIL reload_set: sets %0d addr %h want 1 00000200", n_set - sets0, last_set_addr);
        end
        n_vec++;
        if (seq_data_o !== 64'hFFFF_FDFF_0000_0200) begin
            n_miss++; $display("FAIL reload_data: got %h want fffffdff00000200", seq_data_o);
        end
    endtask

    task automatic test_wrap();
        int t_req; bit ok; int sets0;
        sets0 = n_set;
        issue(1'b1, 32'hFFFF_FFFF, t_req, ok);
        wait_idle(40, ok);
        n_vec++;
        if (n_set - sets0 !== 1 || last_set_addr !== 32'hFFFF_FFFF || host_data_o !== 64'h0000_0000_FFFF_FFFF) begin
            n_miss++; $display("FAIL wrap_first: sets %0d addr %h data %h want 1 ffffffff 00000000ffffffff",
                n_set - sets0, last_set_addr, host_data_o);
        end
        issue(1'b1, 32'h0000_0000, t_req, ok);
        wait_idle(40, ok);
        n_vec++;
        if (n_set - sets0 !== 1 || t_read !== t_req + 1) begin
            n_miss++; $display("FAIL wrap_skip: sets %0d read cycle %0d want 1 %0d", n_set - sets0, t_read, t_req + 1);
        end
        n_vec++;
        if (host_data_o !== 64'hFFFF_FFFF_0000_0000 || owner_o !== 1'b1 || n_host_val !== 2) begin
            n_miss++; $display("FAIL wrap_host: data %h owner %b valids %0d want ffffffff00000000 1 2",
                host_data_o, owner_o, n_host_val);
        end
        n_vec++;
        if (seq_data_o !== 64'hFFFF_FDFF_0000_0200) begin
            n_miss++; $display("FAIL wrap_seq_hold: got %h want fffffdff00000200", seq_data_o);
        end
    endtask

    task automatic test_fairness();
        int sv0, hv0, base; bit ok;
        ram_lat = 1;
        grants = "";
        sv0 = n_seq_val; hv0 = n_host_val;
        base = n_seq_ack + n_host_ack;
        ok = 1'b0;
        seq_addr_i = 32'h0000_0300; host_addr_i = 32'h0000_0400;
        seq_req_i = 1'b1; host_req_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (n_seq_ack + n_host_ack >= base + 10) begin ok = 1'b1; break; end
        end
        seq_req_i = 1'b0; host_req_i = 1'b0;
        n_vec++;
        if (!ok) begin n_miss++; $display("FAIL fair_progress: grants %0d want 10", n_seq_ack + n_host_ack - base); end
        wait_idle(40, ok);
        n_vec++;
        if (grants != "SSSSHSSSSH") begin
            n_miss++; $display("FAIL fair_order: got %s want SSSSHSSSSH", grants);
        end
        n_vec++;
        if (n_seq_val - sv0 !== 8 || n_host_val - hv0 !== 2 || n_misroute !== 0) begin
            n_miss++; $display("FAIL fair_routing: seq %0d host %0d misrouted %0d want 8 2 0",
                n_seq_val - sv0, n_host_val - hv0, n_misroute);
        end
        n_vec++;
        if (seq_data_o !== 64'hFFFF_FCFF_0000_0300 || host_data_o !== 64'hFFFF_FBFF_0000_0400) begin
            n_miss++; $display("FAIL fair_data: seq %h host %h want fffffcff00000300 fffffbff00000400",
                seq_data_o, host_data_o);
        end
        ram_lat = 2;
    endtask

    task automatic test_reset_in_wait();
        int t_req; bit ok; int sv0, sets0;
        ram_lat = 8;
        // 0x401 follows the last host read, so this one goes straight to READ
        issue(1'b0, 32'h0000_0401, t_req, ok);
        repeat (2) tick();
        sv0 = n_seq_val;
        reset_n_i = 1'b0;
        #1;
        n_vec++;
        if ({busy_o, ram_read_o, ram_set_address_o, owner_o} !== 4'b0 || seq_data_o !== 64'h0) begin
            n_miss++; $display("FAIL async_reset: busy/read/set/owner %b data %h want 0000 0",
                {busy_o, ram_read_o, ram_set_address_o, owner_o}, seq_data_o);
        end
        repeat (2) tick();
        reset_n_i = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (n_seq_val !== sv0 || busy_o !== 1'b0 || seq_data_o !== 64'h0) begin
            n_miss++; $display("FAIL stale_response: valids %0d busy %b data %h want %0d 0 0",
                n_seq_val, busy_o, seq_data_o, sv0);
        end
        ram_lat = 2;
        sets0 = n_set;
        issue(1'b0, 32'h0000_0401, t_req, ok);
        wait_idle(40, ok);
        n_vec++;
        if (n_set - sets0 !== 1 || last_set_addr !== 32'h401 || seq_data_o !== 64'hFFFF_FBFE_0000_0401) begin
            n_miss++; $display("FAIL post_reset_set: sets %0d addr %h data %h want 1 00000401 fffffbfe00000401",
                n_set - sets0, last_set_addr, seq_data_o);
        end
    endtask

    task automatic test_timeout();
        int t_req; bit ok; int hv0;
        ram_en = 1'b0;
        hv0 = n_host_val;
        issue(1'b1, 32'h0000_0800, t_req, ok);
`ifdef PP_RAM_ARB_TIMEOUT_EN
        wait_idle(60, ok);
        n_vec++;
        if (!ok || n_host_val - hv0 !== 1 || t_host_val !== t_read + 17) begin
            n_miss++; $display("FAIL timeout_pulse: valids %0d cycle %0d want 1 %0d",
                n_host_val - hv0, t_host_val, t_read + 17);
        end
        n_vec++;
        if (host_data_o !== 64'hFFFF_FFFF_FFFF_FFFF || error_o !== 1'b1) begin
            n_miss++; $display("FAIL timeout_data: data %h error %b want all ones 1", host_data_o, error_o);
        end
        repeat (5) tick();
        n_vec++;
        if (error_o !== 1'b1) begin n_miss++; $display("FAIL timeout_sticky: error %b want 1", error_o); end
`else
        repeat (40) tick();
        n_vec++;
        if (busy_o !== 1'b1 || error_o !== 1'b0 || n_host_val !== hv0) begin
            n_miss++; $display("FAIL wait_forever: busy %b error %b valids %0d want 1 0 %0d",
                busy_o, error_o, n_host_val, hv0);
        end
`endif
        ram_en = 1'b1;
        reset_n_i = 1'b0;
        repeat (2) tick();
        reset_n_i = 1'b1;
        tick();
        n_vec++;
        if (busy_o !== 1'b0 || error_o !== 1'b0) begin
            n_miss++; $display("FAIL final_reset: busy %b error %b want 0 0", busy_o, error_o);
        end
    endtask

    initial begin
        test_reset();
        test_seq_read();
        test_sequential_skip();
        test_wrap();
        test_fairness();
        test_reset_in_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
